// File: rtl/svm_pkg.sv
// Shared types and helpers for the one-vs-one SVM classifier.
package svm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    int unsigned i;
    int unsigned j;
  } pair_t;

  // Number of one-vs-one classifiers for n classes.
  function automatic int unsigned num_pair(input int unsigned n);
    return (n * (n - 1)) / 2;
  endfunction

  // Pair index p -> class pair (i,j), ordered (0,1),(0,2)..(0,n-1),(1,2)..
  function automatic pair_t pair_map(input int unsigned p, input int unsigned n);
    pair_t       r;
    int unsigned k;
    r = '0;
    k = 0;
    for (int unsigned a = 0; a < n; a++) begin
      for (int unsigned b = a + 1; b < n; b++) begin
        if (k == p) begin
          r.i = a;
          r.j = b;
        end
        k++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/svm_pair_mac.sv
// Accumulator for one pairwise decision: adds feat*weight per cycle and
// exposes the sign of the running sum including the current product.
module svm_pair_mac #(
  parameter int unsigned FEAT_W = 5,
  parameter int unsigned W_W    = 8,
  parameter int unsigned ACC_W  = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mac_en,
  input  logic                    load_en,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic [FEAT_W-1:0]       feat,
  input  logic signed [W_W-1:0]   weight,
  output logic                    sum_neg_c
);

  localparam int unsigned PROD_W = FEAT_W + W_W + 1;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  // Signed product of zero-extended feature, resized to the wrapping accumulator.
  always_comb begin
    prod_c     = PROD_W'($signed({1'b0, feat})) * PROD_W'(weight);
    prod_ext_c = ACC_W'(prod_c);
    sum_c      = acc_q + prod_ext_c;
    sum_neg_c  = sum_c[ACC_W-1];
    acc_d      = acc_q;
    if (mac_en) acc_d = sum_c;
    if (load_en) acc_d = load_val;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/svm_ovo_seq.sv
// Sequential one-vs-one linear SVM: one MAC per cycle, pairwise voting,
// then a per-class argmax scan. Optional macro SVM_VOTES_OUT_EN exports
// the final vote counts on out_votes.
module svm_ovo_seq
  import svm_pkg::*;
#(
  parameter int unsigned NUM_FEAT  = 6,
  parameter int unsigned FEAT_W    = 5,
  parameter int unsigned W_W       = 8,
  parameter int unsigned NUM_CLASS = 3,
  parameter int unsigned ACC_W     = 13,
  parameter logic [num_pair(NUM_CLASS)*NUM_FEAT*W_W-1:0] WEIGHTS = {
    8'h4E, 8'hFE, 8'h01, 8'h02, 8'hFF, 8'h01,
    8'h02, 8'hF2, 8'hF3, 8'hF8, 8'h0F, 8'hFB,
    8'hBD, 8'hFE, 8'hF8, 8'hFE, 8'h04, 8'hFA},
  parameter logic [num_pair(NUM_CLASS)*ACC_W-1:0] INTERCEPTS = {
    13'h1F5D, 13'h00BF, 13'h00DE}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0]     in_feat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_CLASS)-1:0]   out_class
`ifdef SVM_VOTES_OUT_EN
  ,
  output logic [NUM_CLASS*$clog2(NUM_CLASS)-1:0] out_votes
`endif
);

  localparam int unsigned NUM_PAIR = num_pair(NUM_CLASS);
  localparam int unsigned CLS_W    = $clog2(NUM_CLASS);
  localparam int unsigned PAIR_W   = (NUM_PAIR > 1) ? $clog2(NUM_PAIR) : 1;
  localparam int unsigned FIDX_W   = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  // Constant lookup tables unpacked from the flat parameters.
  logic signed [W_W-1:0]   wt_tab   [NUM_PAIR][NUM_FEAT];
  logic signed [ACC_W-1:0] icpt_tab [NUM_PAIR];
  logic [CLS_W-1:0]        pi_tab   [NUM_PAIR];
  logic [CLS_W-1:0]        pj_tab   [NUM_PAIR];

  for (genvar gp = 0; gp < NUM_PAIR; gp++) begin : g_pair
    localparam pair_t PM = pair_map(gp, NUM_CLASS);
    assign icpt_tab[gp] = INTERCEPTS[gp*ACC_W +: ACC_W];
    assign pi_tab[gp]   = CLS_W'(PM.i);
    assign pj_tab[gp]   = CLS_W'(PM.j);
    for (genvar gf = 0; gf < NUM_FEAT; gf++) begin : g_feat
      assign wt_tab[gp][gf] = WEIGHTS[(gp*NUM_FEAT+gf)*W_W +: W_W];
    end
  end

  state_e                              state_q, state_d;
  logic [NUM_FEAT-1:0][FEAT_W-1:0]     feat_reg_q, feat_reg_d;
  logic [FIDX_W-1:0]                   fidx_q, fidx_d;
  logic [PAIR_W-1:0]                   pair_q, pair_d;
  logic [CLS_W-1:0]                    cls_q, cls_d;
  logic [NUM_CLASS-1:0][CLS_W-1:0]     votes_q, votes_d;
  logic [CLS_W-1:0]                    best_cls_q, best_cls_d;
  logic [CLS_W-1:0]                    best_cnt_q, best_cnt_d;
  logic                                in_ready_q, in_ready_d;
  logic                                out_valid_q, out_valid_d;
  logic [CLS_W-1:0]                    out_class_q, out_class_d;
  logic                                mac_en_c, load_en_c, sum_neg_c;
  logic signed [ACC_W-1:0]             load_val_c;
  logic [CLS_W-1:0]                    scan_cnt_c;

  svm_pair_mac #(
    .FEAT_W (FEAT_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .mac_en    (mac_en_c),
    .load_en   (load_en_c),
    .load_val  (load_val_c),
    .feat      (feat_reg_q[fidx_q]),
    .weight    (wt_tab[pair_q][fidx_q]),
    .sum_neg_c (sum_neg_c)
  );

  // Next-state, sequencing counters, voting and argmax.
  always_comb begin
    state_d     = state_q;
    feat_reg_d  = feat_reg_q;
    fidx_d      = fidx_q;
    pair_d      = pair_q;
    cls_d       = cls_q;
    votes_d     = votes_q;
    best_cls_d  = best_cls_q;
    best_cnt_d  = best_cnt_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    mac_en_c    = 1'b0;
    load_en_c   = 1'b0;
    load_val_c  = icpt_tab[0];
    scan_cnt_c  = votes_q[cls_q];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          feat_reg_d = in_feat;
          load_en_c  = 1'b1;
          votes_d    = '0;
          fidx_d     = '0;
          pair_d     = '0;
          state_d    = MAC;
        end
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (fidx_q == FIDX_W'(NUM_FEAT - 1)) begin
          // Sum complete for this pair: cast the vote and reload.
          if (sum_neg_c) votes_d[pj_tab[pair_q]] = votes_q[pj_tab[pair_q]] + CLS_W'(1);
          else           votes_d[pi_tab[pair_q]] = votes_q[pi_tab[pair_q]] + CLS_W'(1);
          load_en_c = 1'b1;
          fidx_d    = '0;
          if (pair_q == PAIR_W'(NUM_PAIR - 1)) begin
            load_val_c = icpt_tab[0];
            cls_d      = '0;
            best_cls_d = '0;
            best_cnt_d = '0;
            state_d    = ARGMAX;
          end else begin
            load_val_c = icpt_tab[pair_q + PAIR_W'(1)];
            pair_d     = pair_q + PAIR_W'(1);
          end
        end else begin
          fidx_d = fidx_q + FIDX_W'(1);
        end
      end
      ARGMAX: begin
        // Strictly greater keeps the lower index on ties.
        if (scan_cnt_c > best_cnt_q) begin
          best_cnt_d = scan_cnt_c;
          best_cls_d = cls_q;
        end
        if (cls_q == CLS_W'(NUM_CLASS - 1)) begin
          out_class_d = best_cls_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cls_d = cls_q + CLS_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      feat_reg_q  <= '0;
      fidx_q      <= '0;
      pair_q      <= '0;
      cls_q       <= '0;
      votes_q     <= '0;
      best_cls_q  <= '0;
      best_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
    end else begin
      state_q     <= state_d;
      feat_reg_q  <= feat_reg_d;
      fidx_q      <= fidx_d;
      pair_q      <= pair_d;
      cls_q       <= cls_d;
      votes_q     <= votes_d;
      best_cls_q  <= best_cls_d;
      best_cnt_q  <= best_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;

`ifdef SVM_VOTES_OUT_EN
  logic [NUM_CLASS-1:0][CLS_W-1:0] out_votes_q, out_votes_d;

  // Snapshot of the final votes, published together with the class.
  always_comb begin
    out_votes_d = out_votes_q;
    if (state_q == ARGMAX && state_d == DONE) out_votes_d = votes_q;
  end

  // Vote output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_votes_q <= '0;
    else        out_votes_q <= out_votes_d;
  end

  assign out_votes = out_votes_q;
`else
  // Vote counts stay internal to the argmax.
`endif

endmodule

// File: tb/tb_svm_ovo_seq.sv
// Scoreboard bench for svm_ovo_seq: default-weight instance plus a
// zero-weight instance for the tie case. Honours SVM_VOTES_OUT_EN.
module tb_svm_ovo_seq;

  typedef struct {
    int         cls;
    logic [5:0] votes;
  } exp_t;

  localparam int LAT = 3 * 6 + 3 + 1;

  int W_DEF [3][6] = '{'{-6, 4, -2, -8, -2, -67},
                       '{-5, 15, -8, -13, -14, 2},
                       '{1, -1, 2, 1, -2, 78}};
  int IC_DEF [3] = '{222, 191, -163};
  int IC_Z   [3] = '{1, -1, 1};
  int PI [3] = '{0, 0, 1};
  int PJ [3] = '{1, 2, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv_a, iv_b, ordy_a, ordy_b;
  logic [29:0] feat_a, feat_b;
  wire         ir_a, ir_b, ov_a, ov_b;
  wire  [1:0]  oc_a, oc_b;
`ifdef SVM_VOTES_OUT_EN
  wire  [5:0]  vt_a, vt_b;
`endif

  bit          sel;
  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  svm_ovo_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv_a),
    .in_ready  (ir_a),
    .in_feat   (feat_a),
    .out_valid (ov_a),
    .out_ready (ordy_a),
    .out_class (oc_a)
`ifdef SVM_VOTES_OUT_EN
    ,
    .out_votes (vt_a)
`endif
  );

  svm_ovo_seq #(
    .WEIGHTS    ('0),
    .INTERCEPTS ({13'h0001, 13'h1FFF, 13'h0001})
  ) u_dut_z (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv_b),
    .in_ready  (ir_b),
    .in_feat   (feat_b),
    .out_valid (ov_b),
    .out_ready (ordy_b),
    .out_class (oc_b)
`ifdef SVM_VOTES_OUT_EN
    ,
    .out_votes (vt_b)
`endif
  );

  wire       obs_ready = sel ? ir_b : ir_a;
  wire       obs_valid = sel ? ov_b : ov_a;
  wire [1:0] obs_class = sel ? oc_b : oc_a;
`ifdef SVM_VOTES_OUT_EN
  wire [5:0] obs_votes = sel ? vt_b : vt_a;
`endif

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_votes(input bit z, input logic [29:0] f);
    int         v [3];
    int         s;
    logic [12:0] t;
    v = '{0, 0, 0};
    for (int p = 0; p < 3; p++) begin
      s = z ? IC_Z[p] : IC_DEF[p];
      for (int k = 0; k < 6; k++) s += int'(f[k*5 +: 5]) * (z ? 0 : W_DEF[p][k]);
      t = 13'(s);
      if (t[12]) v[PJ[p]]++;
      else       v[PI[p]]++;
    end
    return {2'(v[2]), 2'(v[1]), 2'(v[0])};
  endfunction

  function automatic int model_class(input logic [5:0] v);
    int best = 0;
    for (int c = 1; c < 3; c++) if (v[c*2 +: 2] > v[best*2 +: 2]) best = c;
    return best;
  endfunction

  task automatic drive_in(input logic v, input logic [29:0] f);
    if (sel) begin iv_b = v; feat_b = f; end
    else     begin iv_a = v; feat_a = f; end
  endtask

  task automatic set_ordy(input logic r);
    if (sel) ordy_b = r;
    else     ordy_a = r;
  endtask

  // Called just after a clock edge; returns #1 after the handshake edge.
  task automatic send(input logic [29:0] f, input int cls, input logic [5:0] votes);
    int n = 0;
    while (!obs_ready && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("in_ready_wait", int'(obs_ready), 1);
    drive_in(1'b1, f);
    sb.push_back('{cls, votes});
    @(posedge clk); #1;
    drive_in(1'b0, 30'($urandom));
  endtask

  task automatic send_model(input logic [29:0] f);
    logic [5:0] v;
    v = model_votes(sel, f);
    send(f, model_class(v), v);
  endtask

  task automatic get_result(input int hold);
    int   n = 0;
    exp_t e;
    set_ordy(hold == 0);
    while (!obs_valid && n < 200) begin
      @(posedge clk); #1; n++;
      // Scramble inputs mid-flight; the registered vector must be used.
      drive_in(1'b0, 30'($urandom));
    end
    check_eq("out_valid_seen", int'(obs_valid), 1);
    check_eq("latency", n + 1, LAT);
    check_eq("in_ready_in_done", int'(obs_ready), 0);
    if (sb.size() == 0) begin
      check_eq("sb_nonempty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check_eq("class", int'(obs_class), e.cls);
`ifdef SVM_VOTES_OUT_EN
    check_eq("votes", int'(obs_votes), int'(e.votes));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", int'(obs_valid), 1);
      check_eq("hold_class", int'(obs_class), e.cls);
      check_eq("hold_in_ready", int'(obs_ready), 0);
    end
    set_ordy(1'b1);
    @(posedge clk); #1;
    check_eq("release_valid", int'(obs_valid), 0);
    check_eq("release_in_ready", int'(obs_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; ordy_a = 1'b1; ordy_b = 1'b1;
    feat_a = '0; feat_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(ov_a), 0);
    check_eq("rst_out_class", int'(oc_a), 0);
    check_eq("rst_in_ready", int'(ir_a), 1);

    // Handshake on the first edge after reset release; all-zero features.
    rst_n = 1'b1;
    send(30'd0, 0, {2'd1, 2'd0, 2'd2});
    get_result(0);

    // Feature 5 = 31: sums -1855, 253, 2255.
    send({5'd31, 25'd0}, 1, {2'd0, 2'd2, 2'd1});
    get_result(0);

    // Back-to-back with a bench model.
    send_model({5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31});
    get_result(0);
    send_model({5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31});
    get_result(0);
    for (int r = 0; r < 6; r++) begin
      send_model(30'($urandom));
      get_result(0);
    end

    // Consumer back-pressure, then immediate next vector.
    send_model(30'($urandom));
    get_result(5);
    send({5'd31, 25'd0}, 1, {2'd0, 2'd2, 2'd1});
    get_result(0);

    // Reset in the middle of MAC discards the result in flight.
    send_model(30'($urandom));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(ov_a), 0);
    check_eq("midrst_out_class", int'(oc_a), 0);
    check_eq("midrst_in_ready", int'(ir_a), 1);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_model({5'd3, 5'd17, 5'd9, 5'd0, 5'd22, 5'd5});
    get_result(0);

    // Zero weights, intercepts {1,-1,1}: three-way tie resolves to class 0.
    sel = 1'b1;
    send(30'($urandom), 0, {2'd1, 2'd1, 2'd1});
    get_result(0);
    send_model(30'($urandom));
    get_result(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svm_ovo_seq.md
SVM_OVO_SEQ -- requirements
Module: svm_ovo_seq

Interface
REQ-001 Parameter NUM_FEAT, default 6: number of features per input vector.
REQ-002 Parameter FEAT_W, default 5: unsigned width of each feature.
REQ-003 Parameter W_W, default 8: signed width of each weight.
REQ-004 Parameter NUM_CLASS, default 3: number of classes; NUM_PAIR = NUM_CLASS*(NUM_CLASS-1)/2.
REQ-005 Parameter ACC_W, default 13: signed accumulator width.
REQ-006 Parameter WEIGHTS, default {-6,4,-2,-8,-2,-67 / -5,15,-8,-13,-14,2 / 1,-1,2,1,-2,78}: flat NUM_PAIR*NUM_FEAT*W_W vector, pair-major, feature 0 at the LSBs.
REQ-007 Parameter INTERCEPTS, default {222,191,-163}: flat NUM_PAIR*ACC_W vector, pair 0 at the LSBs.
REQ-008 clk  input  1  single clock, rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 in_valid  input  1  feature vector valid.
REQ-011 in_ready  output  1  block can accept a vector.
REQ-012 in_feat  input  NUM_FEAT*FEAT_W  features, feature 0 at the LSBs.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_class  output  clog2(NUM_CLASS)  winning class index.

Function
REQ-016 FSM states SHALL be IDLE, MAC, ARGMAX and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 A handshake (in_valid & in_ready) SHALL register in_feat, enter MAC, and load the accumulator with INTERCEPTS[0] and all votes with 0.
REQ-018 MAC SHALL add one product feat[f]*W[p][f] per cycle (feature unsigned zero-extended, product sign-extended/truncated to ACC_W), for pairs p in order (0,1),(0,2)..(0,N-1),(1,2).. and for f = 0..NUM_FEAT-1.
REQ-019 On the last feature of pair (i,j), the final sum SHALL be evaluated; sign bit 0 (sum >= 0) SHALL add a vote to i, otherwise to j, and the accumulator SHALL be reloaded with the next intercept.
REQ-020 Accumulation SHALL wrap modulo 2^ACC_W; no saturation or overflow flag.
REQ-021 ARGMAX SHALL scan votes 0..NUM_CLASS-1, one class per cycle, replacing the best only on a strictly greater count, so ties resolve to the lower index.
REQ-022 Latency: with the handshake in cycle 0, out_valid SHALL rise in cycle NUM_PAIR*NUM_FEAT + NUM_CLASS + 1 (default 22).
REQ-023 In DONE, out_valid=1 and out_class SHALL hold stable until out_ready; on out_ready the FSM SHALL return to IDLE, and in_ready SHALL rise the next cycle (no same-cycle re-accept).
REQ-024 in_feat changes after the handshake SHALL NOT affect the result in progress.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, out_valid=0, out_class=0, accumulator=0 and votes=0, including mid-MAC or mid-DONE; an in-flight result is discarded.
REQ-026 The first handshake SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-027 With SVM_VOTES_OUT_EN defined, an extra output out_votes (NUM_CLASS*clog2(NUM_CLASS) bits, class 0 at the LSBs) SHALL carry the final vote counts, valid with out_valid; without it, the port and its output register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package svm_pkg SHALL hold the FSM state typedef, the NUM_PAIR function and the pair-index-to-(i,j) mapping function.
REQ-029 Multiply-accumulate and sign decision SHALL be a sub-module svm_pair_mac; FSM, vote counters and argmax SHALL stay in svm_ovo_seq.

Verification
REQ-030 Defaults with all features = 0: votes {2,0,1} -> out_class=0 at cycle 22.
REQ-031 Defaults with feature5 = 31 and all others 0: sums -1855, 253, 2255 -> votes {1,2,0} -> out_class=1.
REQ-032 All weights 0 and INTERCEPTS {1,-1,1}: votes {1,1,1} tie -> out_class=0.
REQ-033 Hold out_ready=0 for 5 cycles after out_valid: out_class stays stable and in_ready stays 0; it is released then accepts the next vector one cycle after out_ready.
REQ-034 Pulse rst_n low at cycle 10 of MAC: out_valid=0 immediately; the next vector yields the correct result at full latency.
